// File: rtl/data_clk_gen_mc.sv
// Multi-channel programmable data clock generator.
// One shared divide counter produces NUM_CH slow data clocks, each with its own
// phase offset, plus a one-cycle-delayed level and a rising-edge strobe per channel.
// Divider and phase values are double-buffered: writes land in shadow registers
// and reach the active set on a counter wrap, or on every cycle while stopped.
module data_clk_gen_mc #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 20000,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              clk_rst_n,
    input  logic              en,
    input  logic              div_wr,
    input  logic [CNT_W-1:0]  div_in,
    input  logic              ph_wr,
    input  logic [SEL_W-1:0]  ph_sel,
    input  logic [CNT_W-1:0]  ph_in,
    output logic [NUM_CH-1:0] data_clk,
    output logic [NUM_CH-1:0] data_ready,
    output logic [NUM_CH-1:0] data_stb,
    output logic              cnt_wrap
);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  div_sh;
    logic [CNT_W-1:0]  div_act;
    logic [CNT_W-1:0]  ph_sh  [NUM_CH];
    logic [CNT_W-1:0]  ph_act [NUM_CH];
    logic [CNT_W-1:0]  eff_ph [NUM_CH];
    logic              wrap;
    logic [NUM_CH-1:0] hit;

    // Wrap detect, phase clamping and per-channel toggle enables.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        wrap = (cnt == div_act);
        hit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Phases beyond the divider would never match; clamp them onto the wrap count.
            eff_ph[i] = (ph_act[i] > div_act) ? div_act : ph_act[i];
            hit[i]    = en && (cnt == eff_ph[i]);
        end
    end

    // Divide counter, wrap strobe and shadow-to-active transfer.
    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            cnt      <= '0;
            cnt_wrap <= 1'b0;
            div_act  <= CNT_W'(DEFAULT_DIV);
            // NOTE: these small register arrays are reset explicitly because the
            // phase values must be known (zero) from the first enabled edge.
            for (int i = 0; i < NUM_CH; i++) ph_act[i] <= '0;
        end else if (!en) begin
            // Stopped: counter parked at 0 and new settings apply immediately.
            cnt      <= '0;
            cnt_wrap <= 1'b0;
            div_act  <= div_sh;
            for (int i = 0; i < NUM_CH; i++) ph_act[i] <= ph_sh[i];
        end else if (wrap) begin
            // NOTE: non-blocking assignments mean the transfer sees the pre-edge
            // shadow values, so a write on the wrap cycle waits one more period.
            cnt      <= '0;
            cnt_wrap <= 1'b1;
            div_act  <= div_sh;
            for (int i = 0; i < NUM_CH; i++) ph_act[i] <= ph_sh[i];
        end else begin
            cnt      <= cnt + 1'b1;
            cnt_wrap <= 1'b0;
        end
    end

    // Shadow registers; an out-of-range ph_sel matches no channel and is dropped.
    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            div_sh <= CNT_W'(DEFAULT_DIV);
            for (int i = 0; i < NUM_CH; i++) ph_sh[i] <= '0;
        end else begin
            if (div_wr) div_sh <= div_in;
            for (int i = 0; i < NUM_CH; i++) begin
                if (ph_wr && (int'(ph_sel) == i)) ph_sh[i] <= ph_in;
            end
        end
    end

    // Data clocks toggle once per counter period when the count meets the channel phase.
    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            data_clk <= '0;
        end else begin
            data_clk <= data_clk ^ hit;
        end
    end

    // Delayed level and rising-edge strobe, both one edge behind data_clk.
    always_ff @(posedge clk or negedge clk_rst_n) begin
        if (!clk_rst_n) begin
            data_ready <= '0;
            data_stb   <= '0;
        end else begin
            data_ready <= data_clk;
            data_stb   <= data_clk & ~data_ready;
        end
    end

endmodule
